// File: rtl/sd_adc_decim.sv
// First-order sigma-delta ADC front end: synchronizes the comparator, drives the
// RC feedback bit and decimates the bitstream by counting ones over N-clock windows.
module sd_adc_decim #(
    parameter int MSBO   = 7,
    parameter int SETTLE = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          CompIn,
    input  logic          Ack,
    output logic          FbOut,
    output logic [MSBO:0] ADCout,
    output logic          Valid,
    output logic          Overrun
);

    localparam int W  = MSBO + 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [W-1:0]  WIN_LAST    = {W{1'b1}};
    localparam logic [W-1:0]  WIN_ZERO    = {W{1'b0}};
    localparam logic [W:0]    ONES_ZERO   = {(W+1){1'b0}};
    localparam logic [SW-1:0] SET_ZERO    = {SW{1'b0}};
    localparam logic [SW-1:0] SET_ONE     = SW'(1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // A full window of ones would read N; clamp it to the largest code.
    function automatic logic [W-1:0] sat_result(input logic [W:0] sum);
        logic [W-1:0] res;
        if (sum[W]) begin
            res = {W{1'b1}};
        end else begin
            res = sum[W-1:0];
        end
        return res;
    endfunction

    logic                   sync1_q;
    (* IOB = "TRUE" *) logic sync2_q;

    state_t        state_q,      state_d;
    logic [W-1:0]  win_cnt_q,    win_cnt_d;
    logic [W:0]    ones_q,       ones_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [W-1:0]  adc_q,        adc_d;
    logic          valid_q,      valid_d;
    logic          overrun_q,    overrun_d;

    logic [W:0]    sum_s;
    logic          sample_s;

    // Comparator synchronizer; the second flop doubles as the feedback output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= CompIn;
            sync2_q <= sync1_q;
        end
    end

    // Window sequencing, accumulation and sample handshake next-state logic.
    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        ones_d       = ones_q;
        settle_cnt_d = settle_cnt_q;
        adc_d        = adc_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        sample_s     = 1'b0;
        sum_s        = ones_q + (W+1)'(sync2_q);

        case (state_q)
            ST_IDLE: begin
                win_cnt_d    = WIN_ZERO;
                ones_d       = ONES_ZERO;
                settle_cnt_d = SET_ZERO;
                if (Enable) begin
                    state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE, ST_RUN: begin
                if (!Enable) begin
                    state_d      = ST_IDLE;
                    win_cnt_d    = WIN_ZERO;
                    ones_d       = ONES_ZERO;
                    settle_cnt_d = SET_ZERO;
                end else begin
                    win_cnt_d = win_cnt_q + W'(1);
                    if (win_cnt_q == WIN_LAST) begin
                        ones_d = ONES_ZERO;
                        if (state_q == ST_RUN) begin
                            sample_s = 1'b1;
                        end else if (settle_cnt_q == SETTLE_LAST) begin
                            state_d      = ST_RUN;
                            settle_cnt_d = SET_ZERO;
                        end else begin
                            settle_cnt_d = settle_cnt_q + SET_ONE;
                        end
                    end else begin
                        ones_d = sum_s;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                win_cnt_d    = WIN_ZERO;
                ones_d       = ONES_ZERO;
                settle_cnt_d = SET_ZERO;
            end
        endcase

        // A coincident Ack consumes the old sample, so it is not an overrun.
        if (sample_s) begin
            adc_d   = sat_result(sum_s);
            valid_d = 1'b1;
            if (valid_q) begin
                overrun_d = !Ack;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (Ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            win_cnt_q    <= WIN_ZERO;
            ones_q       <= ONES_ZERO;
            settle_cnt_q <= SET_ZERO;
            adc_q        <= WIN_ZERO;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            ones_q       <= ones_d;
            settle_cnt_q <= settle_cnt_d;
            adc_q        <= adc_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign FbOut   = sync2_q;
    assign ADCout  = adc_q;
    assign Valid   = valid_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_sd_adc_decim.sv
// Directed bench for sd_adc_decim at MSBO=7 (N=256), SETTLE=4.
module tb_sd_adc_decim;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       CompIn;
    logic       Ack;
    logic       FbOut;
    logic [7:0] ADCout;
    logic       Valid;
    logic       Overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic toggle_en = 1'b0;
    int   n_clk;
    logic seen_valid;

    sd_adc_decim #(.MSBO(7), .SETTLE(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Enable  (Enable),
        .CompIn  (CompIn),
        .Ack     (Ack),
        .FbOut   (FbOut),
        .ADCout  (ADCout),
        .Valid   (Valid),
        .Overrun (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        if (toggle_en) CompIn = ~CompIn;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (Valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        Reset  = 1'b1;
        Enable = 1'b0;
        CompIn = 1'b0;
        Ack    = 1'b0;
        #12;
        check_eq("rst_fbout",   32'(FbOut),   32'h0);
        check_eq("rst_adcout",  32'(ADCout),  32'h0);
        check_eq("rst_valid",   32'(Valid),   32'h0);
        check_eq("rst_overrun", 32'(Overrun), 32'h0);

        @(negedge Clk);
        Reset  = 1'b0;
        CompIn = 1'b1;
        tick();
        check_eq("sync_lat1", 32'(FbOut), 32'h0);
        tick();
        check_eq("sync_lat2", 32'(FbOut), 32'h1);

        // All-ones input: first sample five windows after the SETTLE entry edge.
        Enable = 1'b1;
        tick();
        wait_valid(n_clk);
        check_eq("first_valid_clks", 32'(n_clk),   32'd1280);
        check_eq("ones_adc",         32'(ADCout),  32'hFF);
        check_eq("ones_overrun",     32'(Overrun), 32'h0);

        // Switch to 0: two stale ones still reach the next window.
        CompIn = 1'b0;
        repeat (256) tick();
        check_eq("ovr_adc",     32'(ADCout),  32'h02);
        check_eq("ovr_valid",   32'(Valid),   32'h1);
        check_eq("ovr_overrun", 32'(Overrun), 32'h1);

        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_eq("ack_valid",   32'(Valid),   32'h0);
        check_eq("ack_overrun", 32'(Overrun), 32'h0);

        repeat (255) tick();
        check_eq("zero_adc",     32'(ADCout),  32'h00);
        check_eq("zero_valid",   32'(Valid),   32'h1);
        check_eq("zero_overrun", 32'(Overrun), 32'h0);

        // Alternating input; the first window keeps two leading zeros -> 127.
        CompIn    = 1'b1;
        toggle_en = 1'b1;
        repeat (256) tick();
        check_eq("tog_first_adc",     32'(ADCout),  32'h7F);
        check_eq("tog_first_overrun", 32'(Overrun), 32'h1);

        repeat (255) tick();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_eq("ack_on_end_adc",     32'(ADCout),  32'h80);
        check_eq("ack_on_end_valid",   32'(Valid),   32'h1);
        check_eq("ack_on_end_overrun", 32'(Overrun), 32'h0);

        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_eq("ack_idle_valid", 32'(Valid),  32'h0);
        check_eq("ack_idle_adc",   32'(ADCout), 32'h80);

        // Drop Enable when the window count reads 100.
        repeat (98) tick();
        Enable = 1'b0;
        tick();
        seen_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (Valid !== 1'b0) seen_valid = 1'b1;
        end
        check_eq("disable_no_valid", 32'(seen_valid), 32'h0);
        check_eq("disable_keep_adc", 32'(ADCout),     32'h80);

        Enable = 1'b1;
        tick();
        wait_valid(n_clk);
        check_eq("reen_valid_clks", 32'(n_clk),  32'd1280);
        check_eq("reen_adc",        32'(ADCout), 32'h80);

        // Asynchronous reset between edges.
        #2;
        Reset = 1'b1;
        #1;
        check_eq("arst_fbout",   32'(FbOut),   32'h0);
        check_eq("arst_adcout",  32'(ADCout),  32'h0);
        check_eq("arst_valid",   32'(Valid),   32'h0);
        check_eq("arst_overrun", 32'(Overrun), 32'h0);

        @(negedge Clk);
        Reset     = 1'b0;
        toggle_en = 1'b0;
        CompIn    = 1'b1;
        tick();
        wait_valid(n_clk);
        check_eq("post_rst_clks", 32'(n_clk),  32'd1280);
        check_eq("post_rst_adc",  32'(ADCout), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
